// File: rtl/fpro_mem_copy_master_if.sv
// Avalon-MM bus bundle between the copy master and its single-port on-chip RAM slave.
// Word-addressed, 32-bit data, fixed read latency, no waitrequest.
interface fpro_mem_copy_master_if #(
  parameter int ADDR_W = 2
);

  logic              avm_chipselect;
  logic              avm_write;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_chipselect,
    output avm_write,
    output avm_address,
    output avm_byteenable,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_chipselect,
    input  avm_write,
    input  avm_address,
    input  avm_byteenable,
    input  avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/fpro_mem_copy_master.sv
// Avalon-MM master copying len words src->dst inside one fixed-latency RAM slave.
// Optional running checksum of copied words: define FPRO_MEM_COPY_CHECKSUM_EN.
module fpro_mem_copy_master #(
  parameter int ADDR_W = 2,
  parameter int LEN_W  = 3,
  parameter int RD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      src_addr,
  input  logic [ADDR_W-1:0]      dst_addr,
  input  logic [LEN_W-1:0]       len,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_W-1:0]       words_done,
  fpro_mem_copy_master_if.master avm
`ifdef FPRO_MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]            checksum
`endif
);

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] src_ptr_r, src_ptr_s;
  logic [ADDR_W-1:0] dst_ptr_r, dst_ptr_s;
  logic [LEN_W-1:0]  rem_r, rem_s;
  logic [LEN_W-1:0]  wdone_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [31:0]       buf_r, buf_s;

  logic              cs_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [3:0]        be_r;
  logic [31:0]       wdata_r;

  assign avm.avm_chipselect = cs_r;
  assign avm.avm_write      = we_r;
  assign avm.avm_address    = addr_r;
  assign avm.avm_byteenable = be_r;
  assign avm.avm_writedata  = wdata_r;

  // Next-state and datapath update for the copy sequencer.
  always_comb begin
    state_s   = state_r;
    src_ptr_s = src_ptr_r;
    dst_ptr_s = dst_ptr_r;
    rem_s     = rem_r;
    wdone_s   = words_done;
    cnt_s     = cnt_r;
    buf_s     = buf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          src_ptr_s = src_addr;
          dst_ptr_s = dst_addr;
          rem_s     = len;
          wdone_s   = LEN_W'(0);
          if (len == LEN_W'(0)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WT;
          cnt_s   = CNT_W'(RD_LAT);
        end
      end
      ST_WT: begin
        cnt_s = cnt_r - CNT_W'(1);
        if (abort) begin
          state_s = ST_IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          buf_s   = avm.avm_readdata;
          state_s = ST_WR;
        end else begin
          state_s = ST_WT;
        end
      end
      ST_WR: begin
        // An aborted write still reaches the bus, but is not counted.
        if (abort) begin
          state_s = ST_IDLE;
        end else begin
          src_ptr_s = src_ptr_r + ADDR_W'(1);
          dst_ptr_s = dst_ptr_r + ADDR_W'(1);
          wdone_s   = words_done + LEN_W'(1);
          rem_s     = rem_r - LEN_W'(1);
          if (rem_r == LEN_W'(1)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RD;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      src_ptr_r  <= '0;
      dst_ptr_r  <= '0;
      rem_r      <= '0;
      words_done <= '0;
      cnt_r      <= '0;
      buf_r      <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      src_ptr_r  <= src_ptr_s;
      dst_ptr_r  <= dst_ptr_s;
      rem_r      <= rem_s;
      words_done <= wdone_s;
      cnt_r      <= cnt_s;
      buf_r      <= buf_s;
    end
  end

  // Bus and status outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_r    <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      be_r    <= 4'h0;
      wdata_r <= 32'h0000_0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_s != ST_IDLE);
      done <= (state_s == ST_DONE);
      case (state_s)
        ST_RD: begin
          cs_r    <= 1'b1;
          we_r    <= 1'b0;
          addr_r  <= src_ptr_s;
          be_r    <= 4'hF;
          wdata_r <= wdata_r;
        end
        ST_WR: begin
          cs_r    <= 1'b1;
          we_r    <= 1'b1;
          addr_r  <= dst_ptr_s;
          be_r    <= 4'hF;
          wdata_r <= buf_s;
        end
        default: begin
          cs_r    <= 1'b0;
          we_r    <= 1'b0;
          addr_r  <= addr_r;
          be_r    <= 4'h0;
          wdata_r <= wdata_r;
        end
      endcase
    end
  end

`ifdef FPRO_MEM_COPY_CHECKSUM_EN
  // Running modulo-2^32 sum of every word committed by a non-aborted write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 32'h0000_0000;
    end else if ((state_r == ST_IDLE) && start) begin
      checksum <= 32'h0000_0000;
    end else if ((state_r == ST_WR) && !abort) begin
      checksum <= checksum + buf_r;
    end else begin
      checksum <= checksum;
    end
  end
`endif

endmodule

// File: tb/tb_fpro_mem_copy_master.sv
// Self-checking bench for fpro_mem_copy_master: directed plan cases plus random copies
// checked against a word-level reference of the copy against a behavioural RAM slave.
module tb_fpro_mem_copy_master;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 3;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;
`ifdef FPRO_MEM_COPY_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  fpro_mem_copy_master_if #(.ADDR_W(ADDR_W)) bus ();

  fpro_mem_copy_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .avm        (bus)
`ifdef FPRO_MEM_COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM slave with RD_LAT-cycle read pipeline and a bench preload port.
  logic [31:0] mem     [DEPTH];
  logic [31:0] pre_mem [DEPTH];
  logic [31:0] rd_pipe [RD_LAT];
  logic        preload = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre_mem[i];
    end else if (bus.avm_chipselect && bus.avm_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.avm_byteenable[b]) mem[bus.avm_address][8*b +: 8] <= bus.avm_writedata[8*b +: 8];
    end
    if (bus.avm_chipselect && !bus.avm_write) rd_pipe[0] <= mem[bus.avm_address];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.avm_readdata = rd_pipe[RD_LAT-1];

  // Bus monitor, sampled on the falling edge.
  int rd_q[$];
  int wr_q[$];
  int cs_cnt = 0;
  always @(negedge clk) begin
    if (bus.avm_chipselect) begin
      cs_cnt = cs_cnt + 1;
      if (bus.avm_write) wr_q.push_back(int'(bus.avm_address));
      else               rd_q.push_back(int'(bus.avm_address));
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    pre_mem[0] = a; pre_mem[1] = b; pre_mem[2] = c; pre_mem[3] = d;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    cs_cnt = 0;
  endtask

  // Issue one command and compare against the word-level model of an ascending copy.
  task automatic run_copy(input int s, input int d, input int l, input string tag);
    logic [31:0] exp_mem [DEPTH];
    logic [31:0] exp_sum;
    int cyc;
    exp_sum = 32'h0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = mem[i];
    for (int i = 0; i < l; i++) begin
      exp_sum = exp_sum + exp_mem[(s + i) % DEPTH];
      exp_mem[(d + i) % DEPTH] = exp_mem[(s + i) % DEPTH];
    end
    clear_mon();
    src_addr = ADDR_W'(s); dst_addr = ADDR_W'(d); len = LEN_W'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_cycle"}, cyc, l * (2 + RD_LAT) + 1);
    chk({tag, "_busy_in_done"}, {31'h0, busy}, 32'h1);
    chk({tag, "_words_done"}, {29'h0, words_done}, l);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_end"}, {31'h0, done}, 32'h0);
    chk({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    chk({tag, "_n_writes"}, wr_q.size(), l);
    chk({tag, "_n_reads"}, rd_q.size(), l);
    for (int i = 0; i < l && i < wr_q.size(); i++) chk({tag, "_wr_addr"}, wr_q[i], (d + i) % DEPTH);
    for (int i = 0; i < l && i < rd_q.size(); i++) chk({tag, "_rd_addr"}, rd_q[i], (s + i) % DEPTH);
    for (int i = 0; i < DEPTH; i++) chk({tag, "_mem"}, mem[i], exp_mem[i]);
`ifdef FPRO_MEM_COPY_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, exp_sum);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_words_done"}, {29'h0, words_done}, 32'h0);
    chk({tag, "_cs"}, {31'h0, bus.avm_chipselect}, 32'h0);
    chk({tag, "_write"}, {31'h0, bus.avm_write}, 32'h0);
    chk({tag, "_addr"}, {30'h0, bus.avm_address}, 32'h0);
    chk({tag, "_be"}, {28'h0, bus.avm_byteenable}, 32'h0);
    chk({tag, "_wdata"}, bus.avm_writedata, 32'h0);
`ifdef FPRO_MEM_COPY_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] orig [DEPTH];
    int seen_done;
    int wr_before;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    load(32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0);
    run_copy(0, 2, 2, "basic");

    run_copy(1, 3, 0, "zero_len");
    chk("zero_len_cs", cs_cnt, 0);

    load(32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD);
    run_copy(3, 1, 2, "wrap");

    load(32'hFFFF_FFFF, 32'h0000_0002, 32'h0, 32'h0);
    run_copy(0, 2, 2, "csum");

    for (int k = 0; k < 20; k++) begin
      load($urandom, $urandom, $urandom, $urandom);
      run_copy($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 7), "rand");
    end

    // Abort during the second read; a stray start mid-copy must be ignored.
    load(32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404);
    for (int i = 0; i < DEPTH; i++) orig[i] = mem[i];
    clear_mon();
    src_addr = 2'd0; dst_addr = 2'd2; len = 3'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen_done = 0;
    for (int c = 1; c <= 3 + RD_LAT; c++) begin
      start = (c == 2);
      abort = (c == 3 + RD_LAT);
      if (c == 2) begin
        src_addr = 2'd1; dst_addr = 2'd1; len = 3'd7;
      end
      if (done) seen_done = 1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (done) seen_done = 1;
    chk("abort_no_done", seen_done, 0);
    chk("abort_busy_low", {31'h0, busy}, 32'h0);
    chk("abort_words_done", {29'h0, words_done}, 32'h1);
    chk("abort_n_writes", wr_q.size(), 1);
    chk("abort_n_reads", rd_q.size(), 2);
    if (wr_q.size() > 0) chk("abort_wr_addr", wr_q[0], 2);
    if (rd_q.size() > 1) chk("abort_rd2_addr", rd_q[1], 1);
    chk("abort_mem0", mem[0], orig[0]);
    chk("abort_mem1", mem[1], orig[1]);
    chk("abort_mem2", mem[2], orig[0]);
    chk("abort_mem3", mem[3], orig[3]);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_stays_idle", {31'h0, busy}, 32'h0);

    // Asynchronous reset in the wait state.
    load(32'h5, 32'h6, 32'h7, 32'h8);
    clear_mon();
    src_addr = 2'd0; dst_addr = 2'd1; len = 3'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_busy", {31'h0, busy}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    wr_before = wr_q.size();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_write", wr_q.size(), wr_before);
    chk("rst_idle", {31'h0, busy}, 32'h0);
    run_copy(2, 0, 2, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
